// File: rtl/sprite_pkg.sv
// Shared types, default dimensions, colour constants and the built-in sprite
// bitmap table used by the sprite colour mapper.
package sprite_pkg;

    localparam int unsigned DEF_COORD_W    = 10;
    localparam int unsigned DEF_SPR_W      = 16;
    localparam int unsigned DEF_SPR_H      = 16;
    localparam int unsigned DEF_NUM_SHAPES = 4;

    typedef logic [DEF_COORD_W-1:0]            coord_t;
    typedef logic [$clog2(DEF_NUM_SHAPES)-1:0] shape_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Background is a horizontal blue gradient: blue = BG_B_BASE - DrawX[9:3]
    localparam logic [7:0] BG_R      = 8'h00;
    localparam logic [7:0] BG_G      = 8'h00;
    localparam logic [7:0] BG_B_BASE = 8'h7F;

    localparam rgb_t FLASH_COLOR = 24'hFFFFFF;

    // Bitmap table: 0 solid, 1 hollow frame, 2 left half, 3 checkerboard
    function automatic logic shape_pixel(input int unsigned shape, input int unsigned row,
                                         input int unsigned col, input int unsigned w,
                                         input int unsigned h);
        logic bit_on;
        case (shape)
            0:       bit_on = 1'b1;
            1:       bit_on = (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
            2:       bit_on = (col < w / 2);
            default: bit_on = ((row ^ col) & 1) == 0;
        endcase
        return bit_on;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM: one-cycle registered read of a full SPR_W-bit row.
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W      = DEF_SPR_W,
    parameter int unsigned SPR_H      = DEF_SPR_H,
    parameter int unsigned NUM_SHAPES = DEF_NUM_SHAPES
) (
    input  logic                          Clk,
    input  logic [$clog2(NUM_SHAPES)-1:0] shape,
    input  logic [$clog2(SPR_H)-1:0]      row,
    output logic [SPR_W-1:0]              data
);

    // Registered row lookup; bit c of data is column c of the sprite
    always_ff @(posedge Clk) begin
        for (int unsigned c = 0; c < SPR_W; c++) begin
            data[c] <= shape_pixel(32'(shape), 32'(row), c, SPR_W, SPR_H);
        end
    end

endmodule

// File: rtl/sprite_color_mapper.sv
// Composites NUM_OBJ prioritised sprites over a blue gradient in a 3-stage
// pipeline, with per-object hit flash and per-frame collision flags.
module sprite_color_mapper
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_OBJ      = 8,
    parameter int unsigned COORD_W      = DEF_COORD_W,
    parameter int unsigned SPR_W        = DEF_SPR_W,
    parameter int unsigned SPR_H        = DEF_SPR_H,
    parameter int unsigned NUM_SHAPES   = DEF_NUM_SHAPES,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                                       Clk,
    input  logic                                       Reset,
    input  logic                                       frame_start,
    input  logic [COORD_W-1:0]                         DrawX,
    input  logic [COORD_W-1:0]                         DrawY,
    input  logic                                       de,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]            obj_x,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]            obj_y,
    input  logic [NUM_OBJ-1:0]                         obj_en,
    input  logic [NUM_OBJ-1:0][$clog2(NUM_SHAPES)-1:0] obj_shape,
    input  logic [NUM_OBJ-1:0][23:0]                   obj_color,
    input  logic [NUM_OBJ-1:0]                         obj_hit,
    output logic [7:0]                                 Red,
    output logic [7:0]                                 Green,
    output logic [7:0]                                 Blue,
    output logic                                       de_out,
    output logic [NUM_OBJ-1:0]                         coll_flags
);

    localparam int unsigned SHP_W = $clog2(NUM_SHAPES);
    localparam int unsigned COL_W = $clog2(SPR_W);
    localparam int unsigned ROW_W = $clog2(SPR_H);
    localparam int unsigned OFF_W = COORD_W + 1;
    localparam int unsigned FC_W  = $clog2(FLASH_FRAMES + 1);

    logic [NUM_OBJ-1:0][COORD_W-1:0] sh_x, sh_y;
    logic [NUM_OBJ-1:0]              sh_en;
    logic [NUM_OBJ-1:0][SHP_W-1:0]   sh_shape;
    rgb_t [NUM_OBJ-1:0]              sh_color;
    logic [NUM_OBJ-1:0][FC_W-1:0]    flash_cnt;
    logic [NUM_OBJ-1:0]              coll_acc;

    logic [NUM_OBJ-1:0][OFF_W-1:0]   off_x, off_y;
    logic [NUM_OBJ-1:0]              in_box;

    logic                            s1_de, s2_de;
    logic [6:0]                      s1_bx, s2_bx;
    logic [NUM_OBJ-1:0]              s1_in_box, s2_in_box;
    logic [NUM_OBJ-1:0][COL_W-1:0]   s1_col, s2_col;
    logic [NUM_OBJ-1:0][ROW_W-1:0]   s1_row;
    logic [NUM_OBJ-1:0][SPR_W-1:0]   rom_row;

    logic [NUM_OBJ-1:0]              opaque;
    int unsigned                     n_opaque;
    logic                            coll_hit;
    rgb_t                            pix;
    logic                            found;

    // Latch object state at frame start so mid-frame updates never tear
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_x     <= '0;
            sh_y     <= '0;
            sh_en    <= '0;
            sh_shape <= '0;
            sh_color <= '0;
        end else if (frame_start) begin
            sh_x     <= obj_x;
            sh_y     <= obj_y;
            sh_en    <= obj_en;
            sh_shape <= obj_shape;
            sh_color <= obj_color;
        end
    end

    // Per-object bounding box test; the extra offset bit rejects negatives (no wrap)
    always_comb begin
        off_x  = '0;
        off_y  = '0;
        in_box = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            off_x[i]  = {1'b0, DrawX} - {1'b0, sh_x[i]};
            off_y[i]  = {1'b0, DrawY} - {1'b0, sh_y[i]};
            in_box[i] = sh_en[i] && !off_x[i][OFF_W-1] && !off_y[i][OFF_W-1] &&
                        (off_x[i] < OFF_W'(SPR_W)) && (off_y[i] < OFF_W'(SPR_H));
        end
    end

    // S1/S2 pipeline registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_de     <= 1'b0;
            s1_bx     <= '0;
            s1_in_box <= '0;
            s1_col    <= '0;
            s1_row    <= '0;
            s2_de     <= 1'b0;
            s2_bx     <= '0;
            s2_in_box <= '0;
            s2_col    <= '0;
        end else begin
            s1_de     <= de;
            s1_bx     <= DrawX[9:3];
            s1_in_box <= in_box;
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                s1_col[i] <= off_x[i][COL_W-1:0];
                s1_row[i] <= off_y[i][ROW_W-1:0];
            end
            s2_de     <= s1_de;
            s2_bx     <= s1_bx;
            s2_in_box <= s1_in_box;
            s2_col    <= s1_col;
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_rom
        sprite_rom #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .NUM_SHAPES (NUM_SHAPES)
        ) u_rom (
            .Clk   (Clk),
            .shape (sh_shape[g]),
            .row   (s1_row[g]),
            .data  (rom_row[g])
        );
    end

    // Opacity per object and multi-object overlap detection
    always_comb begin
        opaque   = '0;
        n_opaque = 0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            opaque[i] = s2_in_box[i] & rom_row[i][s2_col[i]];
            if (opaque[i]) n_opaque = n_opaque + 1;
        end
        coll_hit = s2_de && (n_opaque >= 2);
    end

    // Priority select: lowest opaque index wins, odd flash count shows white
    always_comb begin
        pix   = '0;
        found = 1'b0;
        pix.r = BG_R;
        pix.g = BG_G;
        pix.b = BG_B_BASE - {1'b0, s2_bx};
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (!found && opaque[i]) begin
                found = 1'b1;
                pix   = flash_cnt[i][0] ? FLASH_COLOR : sh_color[i];
            end
        end
        if (!s2_de) pix = '0;
    end

    // S3 output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red    <= '0;
            Green  <= '0;
            Blue   <= '0;
            de_out <= 1'b0;
        end else begin
            Red    <= pix.r;
            Green  <= pix.g;
            Blue   <= pix.b;
            de_out <= s2_de;
        end
    end

    // Flash counters: a hit reloads and takes precedence over the frame decrement
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flash_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                if (obj_hit[i]) flash_cnt[i] <= FC_W'(FLASH_FRAMES);
                else if (frame_start && flash_cnt[i] != '0) flash_cnt[i] <= flash_cnt[i] - 1'b1;
            end
        end
    end

    // Collision accumulate; a pixel coinciding with frame start seeds the new frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            coll_acc   <= '0;
            coll_flags <= '0;
        end else if (frame_start) begin
            coll_flags <= coll_acc;
            coll_acc   <= coll_hit ? opaque : '0;
        end else if (coll_hit) begin
            coll_acc   <= coll_acc | opaque;
        end
    end

endmodule
